// File: rtl/color_detect_pkg.sv
// Shared definitions for the colour-detect pixel path: raster defaults,
// RGB565 field widths and the output-buffer reader state encoding.
// Pure declarations; no logic and no flow control.
`default_nettype none

package color_detect_pkg;

  // Default raster geometry
  localparam int H_RES_DEF = 640;
  localparam int V_RES_DEF = 480;

  // RGB565 field widths
  localparam int RGB_R_W  = 5;
  localparam int RGB_G_W  = 6;
  localparam int RGB_B_W  = 5;
  localparam int RGB565_W = RGB_R_W + RGB_G_W + RGB_B_W;

  // Output-buffer reader FSM encoding
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_FLUSH = 2'd3
  } rd_state_e;

endpackage

`default_nettype wire

// File: rtl/pix_skid_buf.sv
// Two-entry register FIFO holding {pixel, x, y} between buffer read return and output.
// Latency: a push is visible at the head on the next cycle; the head is read combinationally.
// Backpressure: pushes are dropped when full without a same-cycle pop, so the caller's credit check must prevent that.
`default_nettype none

module pix_skid_buf #(
  parameter int W = 35
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_clr,
  input  logic         i_push,
  input  logic [W-1:0] i_push_dat,
  input  logic         i_pop,
  output logic [W-1:0] o_head_dat,
  output logic [1:0]   o_occ
);

  logic [W-1:0] ent_q [2];
  logic         rd_ptr_q, rd_ptr_d;
  logic         wr_ptr_q, wr_ptr_d;
  logic [1:0]   occ_q, occ_d;
  logic         push_ok, pop_ok;

  // Next pointer/occupancy; a push into a full buffer is allowed only when the head leaves in the same cycle
  always_comb begin
    push_ok  = i_push & ((occ_q != 2'd2) | i_pop);
    pop_ok   = i_pop & (occ_q != 2'd0);
    rd_ptr_d = rd_ptr_q ^ pop_ok;
    wr_ptr_d = wr_ptr_q ^ push_ok;
    occ_d    = occ_q + {1'b0, push_ok} - {1'b0, pop_ok};
    if (i_clr) begin
      rd_ptr_d = 1'b0;
      wr_ptr_d = 1'b0;
      occ_d    = 2'd0;
    end
  end

  // Entry storage and pointer registers
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < 2; i++) ent_q[i] <= '0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      occ_q    <= 2'd0;
    end else begin
      if (!i_clr && push_ok) ent_q[wr_ptr_q] <= i_push_dat;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      occ_q    <= occ_d;
    end
  end

  // Head of queue and fill level
  always_comb begin
    o_head_dat = ent_q[rd_ptr_q];
    o_occ      = occ_q;
  end

endmodule

`default_nettype wire

// File: rtl/obuf_pix_reader.sv
// Pops RGB565 pixels from the filter output buffer and re-emits them as a valid/ready stream with x/y and frame markers.
// Latency: o_obuf_rd at cycle N gives o_valid at N+2 into an empty skid buffer; sustains 1 pixel/cycle with i_ready high.
// Backpressure: at most two pixels (in flight + buffered) outstanding; reads stop when that credit is used up.
// Optional: define OBUF_PIX_READER_UNDERRUN_CNT_EN to add o_underrun_cnt (saturating starved-cycle counter).
`default_nettype none

module obuf_pix_reader
  import color_detect_pkg::*;
#(
  parameter int H_RES = H_RES_DEF,
  parameter int V_RES = V_RES_DEF,
  parameter int DW    = RGB565_W,
  parameter int XW    = 10,
  parameter int YW    = 9
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_enable,
  input  logic          i_flush,
  input  logic [DW-1:0] i_obuf_data,
  input  logic          i_obuf_empty,
  output logic          o_obuf_rd,
  output logic          o_valid,
  input  logic          i_ready,
  output logic [DW-1:0] o_data,
  output logic [XW-1:0] o_x,
  output logic [YW-1:0] o_y,
  output logic          o_sof,
  output logic          o_eol,
  output logic          o_eof,
  output logic          o_busy
`ifdef OBUF_PIX_READER_UNDERRUN_CNT_EN
  ,
  output logic [15:0]   o_underrun_cnt
`endif
);

  localparam int SW = DW + XW + YW;
  localparam logic [XW-1:0] X_LAST = XW'(H_RES - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(V_RES - 1);

  rd_state_e     state_q, state_d;
  logic          flush_2nd_q, flush_2nd_d;
  logic          inflight_q;
  logic [XW-1:0] wr_x_q, wr_x_d;
  logic [YW-1:0] wr_y_q, wr_y_d;

  logic          push, pop;
  logic [1:0]    occ;
  logic [SW-1:0] head;
  logic [DW-1:0] head_dat;
  logic [XW-1:0] head_x;
  logic [YW-1:0] head_y;
  logic [2:0]    used;

  // Return data lands one cycle after the strobe; a flush in that cycle throws it away
  always_comb begin
    push = inflight_q & (state_q != ST_FLUSH) & ~i_flush;
    pop  = o_valid & i_ready;
    used = {2'b00, inflight_q} + {1'b0, occ} - {2'b00, pop};
  end

  pix_skid_buf #(
    .W (SW)
  ) u_skid (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_clr      (i_flush),
    .i_push     (push),
    .i_push_dat ({i_obuf_data, wr_x_q, wr_y_q}),
    .i_pop      (pop),
    .o_head_dat (head),
    .o_occ      (occ)
  );

  // FSM state register plus the FLUSH second-cycle marker
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= ST_IDLE;
      flush_2nd_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      flush_2nd_q <= flush_2nd_d;
    end
  end

  // FSM next state; flush overrides every other transition and restarts the 2-cycle window
  always_comb begin
    state_d     = state_q;
    flush_2nd_d = (state_q == ST_FLUSH) & ~i_flush;
    case (state_q)
      ST_IDLE:  if (i_enable) state_d = ST_RUN;
      ST_RUN:   if (!i_enable) state_d = ST_DRAIN;
      ST_DRAIN: if (!inflight_q && (occ == 2'd0)) state_d = ST_IDLE;
      ST_FLUSH: if (flush_2nd_q) state_d = i_enable ? ST_RUN : ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    if (i_flush) state_d = ST_FLUSH;
  end

  // FSM outputs: read only in RUN with data available and credit left after this cycle's pop
  always_comb begin
    o_obuf_rd = (state_q == ST_RUN) & ~i_flush & ~i_obuf_empty & (used < 3'd2);
    o_busy    = (state_q != ST_IDLE);
  end

  // Capture-side raster position: tags each returned pixel as it enters the skid buffer
  always_comb begin
    wr_x_d = wr_x_q;
    wr_y_d = wr_y_q;
    if (i_flush) begin
      wr_x_d = '0;
      wr_y_d = '0;
    end else if (push) begin
      if (wr_x_q == X_LAST) begin
        wr_x_d = '0;
        wr_y_d = (wr_y_q == Y_LAST) ? '0 : wr_y_q + YW'(1);
      end else begin
        wr_x_d = wr_x_q + XW'(1);
      end
    end
  end

  // In-flight flag and position registers
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      inflight_q <= 1'b0;
      wr_x_q     <= '0;
      wr_y_q     <= '0;
    end else begin
      inflight_q <= o_obuf_rd;
      wr_x_q     <= wr_x_d;
      wr_y_q     <= wr_y_d;
    end
  end

  // Output stream: head entry when buffered, otherwise the position the next pixel will take
  always_comb begin
    {head_dat, head_x, head_y} = head;
    o_valid = (occ != 2'd0) & (state_q != ST_FLUSH) & ~i_flush;
    o_data  = head_dat;
    o_x     = (occ != 2'd0) ? head_x : wr_x_q;
    o_y     = (occ != 2'd0) ? head_y : wr_y_q;
    o_sof   = o_valid & (o_x == '0) & (o_y == '0);
    o_eol   = o_valid & (o_x == X_LAST);
    o_eof   = o_eol & (o_y == Y_LAST);
  end

`ifdef OBUF_PIX_READER_UNDERRUN_CNT_EN
  logic [15:0] urun_q, urun_d;
  logic        urun_hit;

  // Count cycles where a frame is under way, downstream is waiting and the buffer has nothing
  always_comb begin
    urun_hit = (state_q == ST_RUN) & ((o_x != '0) | (o_y != '0)) & i_ready & ~o_valid & i_obuf_empty;
    urun_d   = urun_q;
    if (i_flush) urun_d = '0;
    else if (urun_hit && (urun_q != 16'hFFFF)) urun_d = urun_q + 16'd1;
  end

  // Underrun counter register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) urun_q <= '0;
    else       urun_q <= urun_d;
  end

  assign o_underrun_cnt = urun_q;
`endif

endmodule

`default_nettype wire
